// File: rtl/psg_env_sched.sv
// psg_env_sched
// Controller in front of the PSG attribute RAM write port.
//  - Divides clk down to the PSG next_sample strobe.
//  - Forwards host attribute writes to the PSG with one cycle of latency.
//  - Runs a 16-channel volume-envelope engine. Once every ENV_DIV samples it
//    scans all channels and steps each channel's volume one unit toward its
//    target at that channel's rate. Each change is written back to the
//    channel's volume attribute.
//  - The host always owns the write port. The engine stalls on any cycle
//    that carries a host write, so a host snoop is never overwritten.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   host_addr    [6]=0 PSG attribute address in [5:0];
//                [6]=1 envelope register {ch[3:0], reg[1:0]} in [5:0]
//   host_wrdata  host write data
//   host_write   host write strobe, one cycle per write
//   attr_addr    attribute RAM address to PSG
//   attr_wrdata  attribute RAM data to PSG
//   attr_write   attribute RAM write strobe to PSG
//   next_sample  one-cycle sample strobe to PSG
//   scan_busy    high while the envelope scan runs
module psg_env_sched #(
    parameter int SAMPLE_DIV = 512,
    parameter int ENV_DIV    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] host_addr,
    input  logic [7:0] host_wrdata,
    input  logic       host_write,
    output logic [5:0] attr_addr,
    output logic [7:0] attr_wrdata,
    output logic       attr_write,
    output logic       next_sample,
    output logic       scan_busy
);

    localparam int SCNT_W = $clog2(SAMPLE_DIV);
    localparam int ECNT_W = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;
    localparam logic [SCNT_W-1:0] SCNT_MAX = SCNT_W'(SAMPLE_DIV - 1);
    localparam logic [ECNT_W-1:0] ECNT_MAX = ECNT_W'(ENV_DIV - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Timers
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic              ns_q, ns_d;
    logic [ECNT_W-1:0] ecnt_q, ecnt_d;
    logic              env_start;

    // Scan control
    state_t     state_q, state_d;
    logic [3:0] ch_q, ch_d;

    // Per-channel envelope state
    logic [5:0] cur_q  [16];
    logic [5:0] cur_d  [16];
    logic [5:0] tgt_q  [16];
    logic [5:0] tgt_d  [16];
    logic [1:0] lr_q   [16];
    logic [1:0] lr_d   [16];
    logic [7:0] rate_q [16];
    logic [7:0] rate_d [16];
    logic [7:0] cnt_q  [16];
    logic [7:0] cnt_d  [16];

    // Registered attribute write port
    logic [5:0] attr_addr_q, attr_addr_d;
    logic [7:0] attr_wrdata_q, attr_wrdata_d;
    logic       attr_write_q, attr_write_d;

    // Host decode
    logic [3:0] host_ch;
    logic [1:0] host_reg;

    // Evaluation of the channel under scan
    logic [5:0] sel_cur;
    logic [5:0] sel_tgt;
    logic [1:0] sel_lr;
    logic [7:0] sel_rate;
    logic [8:0] cnt_inc;
    logic       step;
    logic [5:0] new_cur;

    assign host_ch  = host_addr[5:2];
    assign host_reg = host_addr[1:0];

    assign sel_cur  = cur_q[ch_q];
    assign sel_tgt  = tgt_q[ch_q];
    assign sel_lr   = lr_q[ch_q];
    assign sel_rate = rate_q[ch_q];
    // Widened by one bit so cnt+1 cannot wrap before the rate compare.
    assign cnt_inc  = {1'b0, cnt_q[ch_q]} + 9'd1;
    assign step     = (sel_rate != 8'd0) && (cnt_inc >= {1'b0, sel_rate});
    // Only used when cur != tgt, so neither direction can leave 0..63.
    assign new_cur  = (sel_cur < sel_tgt) ? (sel_cur + 6'd1) : (sel_cur - 6'd1);

    // Sample and envelope tick generation
    always_comb begin
        scnt_d = (scnt_q == SCNT_MAX) ? '0 : (scnt_q + SCNT_W'(1));
        ns_d   = (scnt_q == SCNT_MAX);
        ecnt_d = ecnt_q;
        if (ns_q) begin
            ecnt_d = (ecnt_q == ECNT_MAX) ? '0 : (ecnt_q + ECNT_W'(1));
        end
    end

    assign env_start = ns_q && (ecnt_q == ECNT_MAX);

    // Host decode, scan FSM and engine evaluation
    always_comb begin
        state_d       = state_q;
        ch_d          = ch_q;
        cur_d         = cur_q;
        tgt_d         = tgt_q;
        lr_d          = lr_q;
        rate_d        = rate_q;
        cnt_d         = cnt_q;
        attr_addr_d   = attr_addr_q;
        attr_wrdata_d = attr_wrdata_q;
        attr_write_d  = 1'b0;

        if (host_write) begin
            if (!host_addr[6]) begin
                attr_addr_d   = host_addr[5:0];
                attr_wrdata_d = host_wrdata;
                attr_write_d  = 1'b1;
                // Volume attribute writes are mirrored into the engine so
                // it ramps from wherever the host last put the channel.
                if (host_reg == 2'd2) begin
                    cur_d[host_ch] = host_wrdata[5:0];
                    lr_d[host_ch]  = host_wrdata[7:6];
                end
            end else begin
                case (host_reg)
                    2'd0: tgt_d[host_ch] = host_wrdata[5:0];
                    2'd1: begin
                        rate_d[host_ch] = host_wrdata;
                        cnt_d[host_ch]  = 8'd0;
                    end
                    default: ;
                endcase
            end
        end

        case (state_q)
            IDLE: begin
                if (env_start) begin
                    state_d = SCAN;
                    ch_d    = 4'd0;
                end
            end
            SCAN: begin
                // A host write owns this cycle: hold ch and retry next cycle.
                if (!host_write) begin
                    if (sel_rate != 8'd0) begin
                        if (step) begin
                            cnt_d[ch_q] = 8'd0;
                            if (sel_cur != sel_tgt) begin
                                cur_d[ch_q]   = new_cur;
                                attr_addr_d   = {ch_q, 2'b10};
                                attr_wrdata_d = {sel_lr, new_cur};
                                attr_write_d  = 1'b1;
                            end
                        end else begin
                            cnt_d[ch_q] = cnt_inc[7:0];
                        end
                    end
                    if (ch_q == 4'd15) begin
                        state_d = IDLE;
                    end else begin
                        ch_d = ch_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scnt_q        <= '0;
            ns_q          <= 1'b0;
            ecnt_q        <= '0;
            state_q       <= IDLE;
            ch_q          <= 4'd0;
            attr_addr_q   <= 6'd0;
            attr_wrdata_q <= 8'd0;
            attr_write_q  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                cur_q[i]  <= 6'd0;
                tgt_q[i]  <= 6'd0;
                lr_q[i]   <= 2'd0;
                rate_q[i] <= 8'd0;
                cnt_q[i]  <= 8'd0;
            end
        end else begin
            scnt_q        <= scnt_d;
            ns_q          <= ns_d;
            ecnt_q        <= ecnt_d;
            state_q       <= state_d;
            ch_q          <= ch_d;
            attr_addr_q   <= attr_addr_d;
            attr_wrdata_q <= attr_wrdata_d;
            attr_write_q  <= attr_write_d;
            cur_q         <= cur_d;
            tgt_q         <= tgt_d;
            lr_q          <= lr_d;
            rate_q        <= rate_d;
            cnt_q         <= cnt_d;
        end
    end

    assign attr_addr   = attr_addr_q;
    assign attr_wrdata = attr_wrdata_q;
    assign attr_write  = attr_write_q;
    assign next_sample = ns_q;
    assign scan_busy   = (state_q == SCAN);

endmodule
